mdu_sequencer: RTL and testbench

- Multiply/divide sequencer for the P7 pipeline: accepts one MDU operation from the E stage, owns the HI/LO registers and models fixed multi-cycle latency with a busy flag.
- The hazard unit uses `start | busy` to stall MDU-dependent instructions in D.
- The `flush` input cancels a launch in the cycle an exception or interrupt is taken.
- Provides the E-stage read data for mfhi/mflo.

---
 rtl/mdu_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_mdu_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle multiply/divide sequencer owning HI/LO.
// An accepted mult/multu/div/divu latches its operands, holds busy for a
// fixed number of cycles and commits HI/LO on the last busy edge.
// mthi/mtlo write HI/LO directly when idle; mfhi/mflo read them out.
module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic [3:0]         op_r, op_nxt_s;
    logic [31:0]        op_a_r, op_a_nxt_s;
    logic [31:0]        op_b_r, op_b_nxt_s;
    logic [31:0]        hi_r, hi_nxt_s;
    logic [31:0]        lo_r, lo_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic [64:0]        result_s;
    logic               is_arith_s;
    logic               is_mult_s;

    // Result of an arithmetic op: {write_enable, hi, lo}. A zero divisor
    // leaves HI/LO untouched; the signed overflow case is pinned explicitly.
    function automatic logic [64:0] mdu_result(input logic [3:0]  op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sprod;
        logic        [63:0] uprod;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sq;
        logic signed [31:0] sr;
        logic [64:0]        res;
        sa    = $signed(a);
        sb    = $signed(b);
        sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        uprod = {32'd0, a} * {32'd0, b};
        sq    = 32'sd0;
        sr    = 32'sd0;
        case (op)
            OP_MULT:  res = {1'b1, $unsigned(sprod)};
            OP_MULTU: res = {1'b1, uprod};
            OP_DIV: begin
                if (b == 32'd0) begin
                    res = {1'b0, 64'd0};
                end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
                    res = {1'b1, 32'd0, 32'h8000_0000};
                end else begin
                    sq  = sa / sb;
                    sr  = sa % sb;
                    res = {1'b1, $unsigned(sr), $unsigned(sq)};
                end
            end
            OP_DIVU: begin
                if (b == 32'd0) begin
                    res = {1'b0, 64'd0};
                end else begin
                    res = {1'b1, a % b, a / b};
                end
            end
            default: res = {1'b0, 64'd0};
        endcase
        return res;
    endfunction

    assign is_arith_s = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU) ||
                        (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);
    assign is_mult_s  = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
    assign result_s   = mdu_result(op_r, op_a_r, op_b_r);

    // Next-state, counter, operand latch and HI/LO update decisions.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        op_nxt_s    = op_r;
        op_a_nxt_s  = op_a_r;
        op_b_nxt_s  = op_b_r;
        hi_nxt_s    = hi_r;
        lo_nxt_s    = lo_r;
        busy_nxt_s  = busy_r;
        case (state_r)
            ST_IDLE: begin
                busy_nxt_s = 1'b0;
                if (start && !flush && is_arith_s) begin
                    op_nxt_s    = mdu_op;
                    op_a_nxt_s  = rs_val;
                    op_b_nxt_s  = rt_val;
                    cnt_nxt_s   = is_mult_s ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                    state_nxt_s = ST_RUN;
                    busy_nxt_s  = 1'b1;
                end else if (!flush && (mdu_op == OP_MTHI)) begin
                    hi_nxt_s = rs_val;
                end else if (!flush && (mdu_op == OP_MTLO)) begin
                    lo_nxt_s = rs_val;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                busy_nxt_s = 1'b1;
                if (cnt_r == CNT_W'(1)) begin
                    if (result_s[64]) begin
                        hi_nxt_s = result_s[63:32];
                        lo_nxt_s = result_s[31:0];
                    end else begin
                        hi_nxt_s = hi_r;
                        lo_nxt_s = lo_r;
                    end
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    state_nxt_s = ST_IDLE;
                    busy_nxt_s  = 1'b0;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, counter, latched operands and architectural HI/LO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            op_r    <= 4'd0;
            op_a_r  <= 32'd0;
            op_b_r  <= 32'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            op_r    <= op_nxt_s;
            op_a_r  <= op_a_nxt_s;
            op_b_r  <= op_b_nxt_s;
            hi_r    <= hi_nxt_s;
            lo_r    <= lo_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

    // E-stage read mux for mfhi/mflo; sees a value committed at the last edge.
    always_comb begin
        case (mdu_op)
            OP_MFHI: rd_data = hi_r;
            OP_MFLO: rd_data = lo_r;
            default: rd_data = 32'd0;
        endcase
    end

    assign busy = busy_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed and randomized checks against a behavioural
// model that computes results with 64-bit integer arithmetic at acceptance
// and tracks the remaining busy cycles as a plain count.
module tb_mdu_sequencer;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    logic [31:0] m_hi, m_lo;
    int          m_left;
    logic        m_commit;
    logic [63:0] m_res;

    mdu_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
        .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
        .busy(busy), .hi(hi), .lo(lo), .rd_data(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = 64'd0;
        case (op)
            4'd1: res = 64'(sa * sb);
            4'd2: res = ua * ub;
            4'd3: begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
            4'd4: begin res = {32'(ua % ub), 32'(ua / ub)}; end
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    // advance model by one clock edge using the inputs present at that edge
    task automatic model_edge();
        if (!reset) begin
            m_hi = 32'd0; m_lo = 32'd0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_commit) begin
                m_hi = m_res[63:32];
                m_lo = m_res[31:0];
            end
        end else if (start && !flush && mdu_op >= 4'd1 && mdu_op <= 4'd4) begin
            m_left   = (mdu_op <= 4'd2) ? MULT_N : DIV_N;
            m_commit = !(mdu_op >= 4'd3 && rt_val == 32'd0);
            if (m_commit) m_res = ref_result(mdu_op, rs_val, rt_val);
        end else if (!flush && mdu_op == 4'd7) begin
            m_hi = rs_val;
        end else if (!flush && mdu_op == 4'd8) begin
            m_lo = rs_val;
        end
    endtask

    task automatic cycle();
        logic [31:0] exp_rd;
        @(posedge clk);
        model_edge();
        #1;
        check_val("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
        check_val("hi", hi, m_hi);
        check_val("lo", lo, m_lo);
        exp_rd = (mdu_op == 4'd5) ? m_hi : (mdu_op == 4'd6) ? m_lo : 32'd0;
        check_val("rd_data", rd_data, exp_rd);
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic st, input logic fl);
        mdu_op = op; rs_val = a; rt_val = b; start = st; flush = fl;
        cycle();
    endtask

    task automatic idle();
        drive(4'd0, $urandom, $urandom, 1'b0, 1'b0);
    endtask

    // launch an arithmetic op, count busy cycles until it falls (bounded)
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int cnt;
        cnt = 0;
        drive(op, a, b, 1'b1, 1'b0);
        for (int i = 0; i < 40 && busy; i++) begin
            cnt++;
            idle();
        end
        check_val("busy_len", 32'(cnt), (op <= 4'd2) ? 32'(MULT_N) : 32'(DIV_N));
    endtask

    initial begin
        m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_commit = 1'b0; m_res = 64'd0;
        reset = 1'b0; start = 1'b0; mdu_op = 4'd0; rs_val = 32'd0; rt_val = 32'd0; flush = 1'b0;
        #2;
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_hi", hi, 32'd0);
        check_val("rst_lo", lo, 32'd0);
        cycle(); cycle();
        reset = 1'b1;

        run_op(4'd1, 32'd3, 32'd4);
        check_val("mult_lo", lo, 32'd12);
        check_val("mult_hi", hi, 32'd0);
        run_op(4'd1, 32'hFFFF_FFFE, 32'd3);
        check_val("smult_hi", hi, 32'hFFFF_FFFF);
        check_val("smult_lo", lo, 32'hFFFF_FFFA);
        run_op(4'd2, 32'hFFFF_FFFE, 32'd3);
        check_val("umult_hi", hi, 32'h2);
        check_val("umult_lo", lo, 32'hFFFF_FFFA);
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2);
        check_val("div_lo", lo, 32'hFFFF_FFFD);
        check_val("div_hi", hi, 32'hFFFF_FFFF);
        run_op(4'd4, 32'd7, 32'd0);
        check_val("divz_lo", lo, 32'hFFFF_FFFD);
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check_val("divov_lo", lo, 32'h8000_0000);
        check_val("divov_hi", hi, 32'd0);

        // flush gating
        drive(4'd1, 32'd5, 32'd6, 1'b1, 1'b1);
        check_val("flush_busy", {31'd0, busy}, 32'd0);
        drive(4'd8, 32'h1234, 32'd0, 1'b0, 1'b1);
        check_val("flush_mtlo", lo, 32'h8000_0000);
        drive(4'd2, 32'd100, 32'd7, 1'b1, 1'b0);
        for (int i = 0; i < MULT_N; i++) drive(4'd7, $urandom, $urandom, 1'b1, 1'b1);
        check_val("flush_run_lo", lo, 32'd700);

        // busy protection: start div and mthi while running
        drive(4'd1, 32'd9, 32'd9, 1'b1, 1'b0);
        drive(4'd3, 32'd50, 32'd5, 1'b1, 1'b0);
        drive(4'd7, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 20 && m_left > 0; i++) idle();
        check_val("prot_lo", lo, 32'd81);
        check_val("prot_hi", hi, 32'd0);

        // back-to-back: start in the cycle busy falls
        drive(4'd1, 32'd2, 32'd21, 1'b1, 1'b0);
        for (int i = 0; i < 20 && m_left > 0; i++) idle();
        drive(4'd3, 32'd100, 32'd7, 1'b1, 1'b0);
        check_val("b2b_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 20 && m_left > 0; i++) idle();
        check_val("b2b_lo", lo, 32'd14);
        check_val("b2b_hi", hi, 32'd2);

        // mid-op reset
        drive(4'd1, 32'd7, 32'd7, 1'b1, 1'b0);
        idle(); idle();
        reset = 1'b0;
        #1;
        m_hi = 32'd0; m_lo = 32'd0; m_left = 0;
        check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_val("mid_rst_hi", hi, 32'd0);
        check_val("mid_rst_lo", lo, 32'd0);
        idle();
        reset = 1'b1;

        // moves
        drive(4'd7, 32'hAAAA_5555, 32'd0, 1'b0, 1'b0);
        mdu_op = 4'd5; #1;
        check_val("mfhi", rd_data, 32'hAAAA_5555);
        drive(4'd8, 32'h0F0F_1234, 32'd0, 1'b0, 1'b0);
        mdu_op = 4'd6; #1;
        check_val("mflo", rd_data, 32'h0F0F_1234);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            logic        fl;
            op = 4'($urandom_range(0, 9));
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 20));
                default: b = 32'($urandom);
            endcase
            fl = ($urandom_range(0, 9) == 0);
            drive(op, a, b, (op >= 4'd1 && op <= 4'd4), fl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
